// File: rtl/uart_tx_frame.sv
// UART transmit framer: serialises an accepted word as start bit, data LSB first,
// optional parity and stop bit(s), advancing only on baud ticks from clk_bps.
module uart_tx_frame #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clk_bps,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 uart_tx,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int               CNT_W    = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_PAR   = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;

    logic [2:0]           r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [CNT_W-1:0]     r_bitCnt;
    logic                 r_stopCnt;
    logic                 r_parity;
    logic                 r_tx;
    logic                 w_accept;
    logic                 w_lastStop;

    assign w_accept   = tx_valid && tx_ready;
    assign w_lastStop = (STOP_BITS == 1) || r_stopCnt;
    assign tx_ready   = (r_state == S_IDLE);
    assign tx_busy    = (r_state != S_IDLE);
    assign uart_tx    = r_tx;

    // Pulses during the final tick itself, so IDLE (and tx_ready) follows on the next cycle.
    assign tx_done = (r_state == S_STOP) && clk_bps && w_lastStop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bitCnt  <= '0;
            r_stopCnt <= 1'b0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A tick coinciding with accept is deliberately not treated as the start tick.
                    if (w_accept) begin
                        r_shift   <= tx_data;
                        r_parity  <= (PARITY == 1) ? ~^tx_data : ^tx_data;
                        r_bitCnt  <= '0;
                        r_stopCnt <= 1'b0;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (clk_bps) begin
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (clk_bps) begin
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (clk_bps) begin
                        if (r_bitCnt == LAST_BIT) begin
                            if (PARITY != 0) begin
                                r_tx    <= r_parity;
                                r_state <= S_PAR;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_tx     <= r_shift[0];
                            r_shift  <= r_shift >> 1;
                            r_bitCnt <= r_bitCnt + CNT_W'(1);
                        end
                    end
                end
                S_PAR: begin
                    if (clk_bps) begin
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (clk_bps) begin
                        if (w_lastStop) begin
                            r_tx    <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_stopCnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmit framer. Sits directly downstream of the baud tick generator and consumes its `clk_bps` pulse, one clock wide once per bit period.
- Accepts parallel bytes over a valid/ready handshake.
- Serialises each byte onto `uart_tx` as start bit, data bits LSB first, optional parity, then stop bit(s).
- Every line transition is aligned to `clk_bps`.

Parameters:
- `DATA_BITS`, default 8: data bits per frame. Legal range 5..8.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: stop bits per frame. Legal values 1 or 2.

Ports:
- `clk`  input  1: main system clock, 100 MHz.
- `rst_n`  input  1: asynchronous active-low reset.
- `clk_bps`  input  1: baud tick. One-cycle high pulse per bit period, from the baud generator.
- `tx_data`  input  DATA_BITS: byte to send. Sampled only on accept.
- `tx_valid`  input  1: source has a byte. Held until accepted.
- `tx_ready`  output  1: framer can accept. High only in IDLE.
- `uart_tx`  output  1: serial line, idle high. Registered.
- `tx_busy`  output  1: high from accept until frame complete.
- `tx_done`  output  1: one-cycle pulse when the last stop bit period ends.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values: `uart_tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0, state=IDLE, bit counter=0.
  - Reset asserted mid-frame forces these values immediately. The partial frame is abandoned.
  - No accept occurs while `rst_n` is low.
- States: IDLE, WAIT, START, DATA, PAR, STOP.
- IDLE:
  - `tx_valid`&&`tx_ready` accepts the byte: latch `tx_data` into a shift register and compute parity from the latched value.
  - Go to WAIT. `tx_busy` rises in the next cycle.
  - A `clk_bps` pulse in the same cycle as accept is NOT used as the start tick.
- WAIT: on the next `clk_bps`, drive `uart_tx`=0 and go to START.
- START: on `clk_bps`, drive data bit 0 and go to DATA.
- DATA:
  - Each `clk_bps` drives the next bit, LSB first, and increments the bit counter.
  - After bit DATA_BITS-1 has been held one full period: the tick drives the parity bit (PAR) if PARITY≠0, otherwise drives 1 (STOP).
- Parity:
  - Odd parity: the parity bit is the XNOR-reduce of the data bits.
  - Even parity: the parity bit is the XOR-reduce.
- PAR: on `clk_bps`, drive 1 and go to STOP.
- STOP:
  - Each `clk_bps` ends one stop period.
  - When STOP_BITS periods have elapsed: pulse `tx_done` for one cycle, clear `tx_busy`, return to IDLE with `uart_tx`=1.
  - `tx_ready` is high from the following cycle.
- Line timing:
  - `uart_tx` changes in the cycle after the `clk_bps` pulse that causes the change (registered).
  - Each bit is held exactly one tick period.
- Tick count per frame, counting the start tick as tick 0: `tx_done` asserts on tick 1+DATA_BITS+(PARITY≠0)+STOP_BITS. This is tick 10 for 8N1.
- Back-to-back: the earliest next accept is the cycle after `tx_done`. Its start bit waits for the following tick, so no idle gap beyond that tick alignment.
- Ignored inputs:
  - `tx_valid` outside IDLE is ignored. The source holds it.
  - Changes to `tx_data` after accept have no effect.
- Ticks:
  - Every cycle with `clk_bps`=1 counts as one tick.
  - Ticks in IDLE are ignored.
- Bit counter width: $clog2(DATA_BITS). It resets to 0 on every accept.

Test Plan:
1. 8N1, `clk_bps` every 16 clocks, send 0x55.
   - `uart_tx` sequence per tick period: 0,1,0,1,0,1,0,1,0,1. Each bit is 16 clocks wide.
   - `tx_done` one cycle on tick 10. `tx_ready` high on the next cycle.
2. Reset mid-frame: assert `rst_n`=0 during data bit 3 of 0xA3.
   - `uart_tx`=1, `tx_busy`=0, `tx_ready`=1 immediately.
   - After release, a new 0x0F transmits correctly.
3. `tx_valid` and `clk_bps` high in the same IDLE cycle, data 0x80.
   - Start bit begins only after the next tick.
   - Line: 0, 0×7 data bits, 1 (MSB), 1 (stop).
4. PARITY=2 (even), data 0x07: parity bit 1. PARITY=1 (odd), data 0x07: parity bit 0. Frame is 11 tick periods.
5. Back-to-back: `tx_valid` held high with 0x12 then 0x34.
   - Second accept on the cycle after `tx_done`.
   - Second start bit at the next tick.
   - `tx_data` changed during the frame does not corrupt 0x12.
6. STOP_BITS=2, DATA_BITS=7, data 0x7F.
   - Line high for 2 periods after data.
   - `tx_done` on tick 10. `tx_valid` asserted mid-frame is not accepted until IDLE.
